// File: rtl/tlul_pkg.sv
// tlul_pkg: TL-UL opcode/size constants and master FSM state encoding
package tlul_pkg;
  localparam logic [2:0] OP_PUT_FULL    = 3'd0;
  localparam logic [2:0] OP_PUT_PARTIAL = 3'd1;
  localparam logic [2:0] OP_GET         = 3'd4;
  localparam logic [2:0] OP_ACK         = 3'd0;
  localparam logic [2:0] OP_ACK_DATA    = 3'd1;
  localparam logic [1:0] SIZE_WORD      = 2'd2;
  typedef enum logic [1:0] {IDLE, A_REQ, D_WAIT, RSP} state_e;
endpackage

// File: rtl/tlul_master_leds.sv
// tlul_master_leds: single-outstanding TL-UL master turning local commands into A/D transactions
// Ports: i_clk/i_reset; local cmd (i_cmd_*, o_cmd_ready); one-cycle response (o_rsp_*);
// TL-UL A channel (o_a_*, i_a_ready); TL-UL D channel (i_d_*, o_d_ready).
module tlul_master_leds
  import tlul_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_cmd_valid,
  output logic              o_cmd_ready,
  input  logic              i_cmd_write,
  input  logic [ADDR_W-1:0] i_cmd_addr,
  input  logic [31:0]       i_cmd_wdata,
  input  logic [3:0]        i_cmd_mask,
  output logic              o_rsp_valid,
  output logic [31:0]       o_rsp_rdata,
  output logic              o_rsp_error,
  output logic              o_a_valid,
  input  logic              i_a_ready,
  output logic [2:0]        o_a_opcode,
  output logic [1:0]        o_a_size,
  output logic [7:0]        o_a_source,
  output logic [ADDR_W-1:0] o_a_address,
  output logic [3:0]        o_a_mask,
  output logic [31:0]       o_a_data,
  input  logic              i_d_valid,
  output logic              o_d_ready,
  input  logic [2:0]        i_d_opcode,
  input  logic [7:0]        i_d_source,
  input  logic [31:0]       i_d_data,
  input  logic              i_d_error
);
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  state_e state_q, state_d;
  logic              wr_q, wr_d, err_q, err_d;
  logic [2:0]        op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        mask_q, mask_d;
  logic [31:0]       data_q, data_d, rdata_q, rdata_d;
  logic [7:0]        src_q, src_d, iss_q, iss_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              accept, a_hs, timeout;
  assign accept  = state_q == IDLE && i_cmd_valid;
  assign a_hs    = state_q == A_REQ && i_a_ready;
  // D_WAIT lasts TIMEOUT_CYC cycles (counter 0..TIMEOUT_CYC-1) before aborting
  assign timeout = cnt_q == CW'(TIMEOUT_CYC - 1);
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= IDLE;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      op_q    <= '0;
      addr_q  <= '0;
      mask_q  <= '0;
      data_q  <= '0;
      rdata_q <= '0;
      src_q   <= '0;
      iss_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      err_q   <= err_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      mask_q  <= mask_d;
      data_q  <= data_d;
      rdata_q <= rdata_d;
      src_q   <= src_d;
      iss_q   <= iss_d;
      cnt_q   <= cnt_d;
    end
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = i_cmd_valid ? A_REQ : IDLE;
      A_REQ:   state_d = i_a_ready ? D_WAIT : A_REQ;
      D_WAIT:  state_d = (i_d_valid || timeout) ? RSP : D_WAIT;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    wr_d    = wr_q;
    err_d   = err_q;
    op_d    = op_q;
    addr_d  = addr_q;
    mask_d  = mask_q;
    data_d  = data_q;
    rdata_d = rdata_q;
    src_d   = src_q;
    iss_d   = iss_q;
    cnt_d   = cnt_q;
    if (accept) begin
      wr_d   = i_cmd_write;
      op_d   = !i_cmd_write ? OP_GET : (i_cmd_mask == 4'hF) ? OP_PUT_FULL : OP_PUT_PARTIAL;
      addr_d = i_cmd_addr & ~ADDR_W'(3);
      mask_d = i_cmd_write ? i_cmd_mask : 4'hF;
      data_d = i_cmd_write ? i_cmd_wdata : 32'h0;
    end
    if (a_hs) begin
      iss_d = src_q;
      src_d = src_q + 8'd1;
      cnt_d = '0;
    end
    if (state_q == D_WAIT) begin
      cnt_d = cnt_q + CW'(1);
      if (i_d_valid) begin
        rdata_d = wr_q ? 32'h0 : i_d_data;
        // a response must echo our ID and carry the ack type matching the request
        err_d   = i_d_error | (i_d_source != iss_q) | (i_d_opcode != (wr_q ? OP_ACK : OP_ACK_DATA));
      end else if (timeout) begin
        rdata_d = 32'h0;
        err_d   = 1'b1;
      end
    end
  end
  always_comb begin
    o_cmd_ready = state_q == IDLE;
    o_a_valid   = state_q == A_REQ;
    o_d_ready   = state_q == IDLE || state_q == D_WAIT;
    o_rsp_valid = state_q == RSP;
    o_rsp_rdata = state_q == RSP ? rdata_q : 32'h0;
    o_rsp_error = state_q == RSP && err_q;
    o_a_size    = state_q == A_REQ ? SIZE_WORD : 2'd0;
    o_a_opcode  = op_q;
    o_a_source  = src_q;
    o_a_address = addr_q;
    o_a_mask    = mask_q;
    o_a_data    = data_q;
  end
endmodule

// File: tb/tb_tlul_master_leds.sv
// tb_tlul_master_leds: table-driven and directed checks of the TL-UL master
module tb_tlul_master_leds;
  localparam int T = 255;
  logic clk = 0, rst = 1;
  logic cmd_valid = 0, cmd_write = 0, a_ready = 0, d_valid = 0, d_error = 0;
  logic [31:0] cmd_addr = 0, cmd_wdata = 0, d_data = 0;
  logic [3:0] cmd_mask = 0;
  logic [2:0] d_opcode = 0;
  logic [7:0] d_source = 0;
  logic cmd_ready, rsp_valid, rsp_error, a_valid, d_ready;
  logic [31:0] rsp_rdata, a_address, a_data;
  logic [2:0] a_opcode;
  logic [1:0] a_size;
  logic [7:0] a_source;
  logic [3:0] a_mask;
  logic [7:0] src_m = 0;
  int n_cmp = 0, n_bad = 0;
  always #5 clk = ~clk;
  tlul_master_leds #(.ADDR_W(32), .TIMEOUT_CYC(T)) dut (
    .i_clk(clk), .i_reset(rst),
    .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready), .i_cmd_write(cmd_write),
    .i_cmd_addr(cmd_addr), .i_cmd_wdata(cmd_wdata), .i_cmd_mask(cmd_mask),
    .o_rsp_valid(rsp_valid), .o_rsp_rdata(rsp_rdata), .o_rsp_error(rsp_error),
    .o_a_valid(a_valid), .i_a_ready(a_ready), .o_a_opcode(a_opcode), .o_a_size(a_size),
    .o_a_source(a_source), .o_a_address(a_address), .o_a_mask(a_mask), .o_a_data(a_data),
    .i_d_valid(d_valid), .o_d_ready(d_ready), .i_d_opcode(d_opcode), .i_d_source(d_source),
    .i_d_data(d_data), .i_d_error(d_error)
  );
  typedef struct {
    logic wr; logic [31:0] addr, wdata; logic [3:0] mask;
    logic [2:0] dop; logic [7:0] soff; logic derr; logic [31:0] ddata;
    logic [2:0] eop; logic [3:0] emask; logic [31:0] eaddr, edata, erdata; logic eerr;
  } vec_t;
  vec_t vec [8];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask
  task automatic run(input vec_t v);
    @(negedge clk);
    cmd_valid = 1; cmd_write = v.wr; cmd_addr = v.addr; cmd_wdata = v.wdata; cmd_mask = v.mask;
    a_ready = 1; d_valid = 1; d_source = 8'(src_m + v.soff); d_opcode = v.dop;
    d_data = v.ddata; d_error = v.derr;
    chk("cmd_ready idle", cmd_ready, 1);
    @(negedge clk);
    cmd_valid = 0;
    chk("a_valid", a_valid, 1);
    chk("a_opcode", a_opcode, v.eop);
    chk("a_mask", a_mask, v.emask);
    chk("a_address", a_address, v.eaddr);
    chk("a_data", a_data, v.edata);
    chk("a_source", a_source, src_m);
    chk("a_size", a_size, 2);
    chk("d_ready in a_req", d_ready, 0);
    @(negedge clk);
    chk("rsp early", rsp_valid, 0);
    chk("d_ready in d_wait", d_ready, 1);
    @(negedge clk);
    chk("rsp_valid cycle4", rsp_valid, 1);
    chk("rsp_rdata", rsp_rdata, v.erdata);
    chk("rsp_error", rsp_error, v.eerr);
    src_m++;
    @(negedge clk);
    chk("rsp one pulse", rsp_valid, 0);
    chk("back to idle", cmd_ready, 1);
  endtask
  initial begin
    int k;
    vec[0] = '{1, 32'h0, 32'hA5, 4'hF, 3'd0, 8'd0, 0, 32'h0, 3'd0, 4'hF, 32'h0, 32'hA5, 32'h0, 0};
    vec[1] = '{0, 32'h0, 32'h0, 4'hF, 3'd1, 8'd0, 0, 32'h3C, 3'd4, 4'hF, 32'h0, 32'h0, 32'h3C, 0};
    vec[2] = '{1, 32'h1237, 32'hDEADBEEF, 4'h3, 3'd0, 8'd0, 0, 32'h0, 3'd1, 4'h3, 32'h1234, 32'hDEADBEEF, 32'h0, 0};
    vec[3] = '{0, 32'h40, 32'h0, 4'hF, 3'd1, 8'd1, 0, 32'h1111, 3'd4, 4'hF, 32'h40, 32'h0, 32'h1111, 1};
    vec[4] = '{1, 32'h8, 32'h55, 4'hF, 3'd0, 8'd0, 1, 32'h0, 3'd0, 4'hF, 32'h8, 32'h55, 32'h0, 1};
    vec[5] = '{0, 32'hC, 32'h0, 4'hF, 3'd0, 8'd0, 0, 32'h77, 3'd4, 4'hF, 32'hC, 32'h0, 32'h77, 1};
    vec[6] = '{1, 32'h10, 32'h99, 4'hF, 3'd1, 8'd0, 0, 32'h5A5A, 3'd0, 4'hF, 32'h10, 32'h99, 32'h0, 1};
    vec[7] = '{0, 32'hFFFF_FFFE, 32'h0, 4'h2, 3'd1, 8'd0, 0, 32'hCAFE_F00D, 3'd4, 4'hF, 32'hFFFF_FFFC, 32'h0, 32'hCAFE_F00D, 0};
    #3;
    chk("rst cmd_ready", cmd_ready, 1);
    chk("rst d_ready", d_ready, 1);
    chk("rst a_valid", a_valid, 0);
    chk("rst rsp_valid", rsp_valid, 0);
    chk("rst rsp_error", rsp_error, 0);
    chk("rst rsp_rdata", rsp_rdata, 0);
    chk("rst a_source", a_source, 0);
    chk("rst a_opcode", a_opcode, 0);
    chk("rst a_address", a_address, 0);
    chk("rst a_size", a_size, 0);
    chk("rst a_mask", a_mask, 0);
    chk("rst a_data", a_data, 0);
    @(negedge clk);
    rst = 0;
    for (int i = 0; i < 8; i++) run(vec[i]);
    // A channel back-pressure: fields must hold while a_ready is low
    @(negedge clk);
    cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h20; cmd_wdata = 32'h1234_5678; cmd_mask = 4'h1;
    a_ready = 0; d_valid = 1; d_source = src_m; d_opcode = 3'd0; d_error = 0;
    @(negedge clk);
    cmd_valid = 0;
    for (int i = 0; i < 5; i++) begin
      chk("stall a_valid", a_valid, 1);
      chk("stall a_opcode", a_opcode, 1);
      chk("stall a_mask", a_mask, 4'h1);
      chk("stall a_address", a_address, 32'h20);
      chk("stall a_data", a_data, 32'h1234_5678);
      chk("stall a_source", a_source, src_m);
      chk("stall no rsp", rsp_valid, 0);
      if (i == 4) a_ready = 1;
      @(negedge clk);
    end
    chk("stall d_wait no rsp", rsp_valid, 0);
    @(negedge clk);
    chk("stall rsp_valid", rsp_valid, 1);
    chk("stall rsp_error", rsp_error, 0);
    src_m++;
    // D beats arriving while idle are dropped
    d_source = src_m;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("idle d beat no rsp", rsp_valid, 0);
    end
    // timeout: no D response at all
    d_valid = 0; a_ready = 1;
    cmd_valid = 1; cmd_write = 0; cmd_addr = 32'h30;
    @(negedge clk);
    cmd_valid = 0;
    chk("to a_valid", a_valid, 1);
    k = 0;
    while (k < 1000) begin
      @(negedge clk);
      k++;
      if (rsp_valid) break;
    end
    chk("timeout edges after handshake", k, T + 1);
    chk("timeout rsp_error", rsp_error, 1);
    chk("timeout rsp_rdata", rsp_rdata, 0);
    src_m++;
    // reset in D_WAIT abandons the transaction
    @(negedge clk);
    cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h4; cmd_mask = 4'hF;
    @(negedge clk);
    cmd_valid = 0;
    @(negedge clk);
    chk("pre-rst d_wait cmd_ready", cmd_ready, 0);
    chk("pre-rst d_wait d_ready", d_ready, 1);
    #2 rst = 1;
    #1;
    chk("async rst cmd_ready", cmd_ready, 1);
    chk("async rst a_source", a_source, 0);
    chk("async rst rsp_valid", rsp_valid, 0);
    @(negedge clk);
    rst = 0;
    src_m = 0;
    d_valid = 1; d_source = 8'h3;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post-rst no rsp", rsp_valid, 0);
    end
    // 257 transactions: the last one is issued with source 0 again
    for (int i = 0; i < 257; i++) run(vec[0]);
    chk("source wrapped", a_source, 8'h01);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
